// File: rtl/pxs_stream_gen_if.sv
// Pixel-stream source bundle: advance enable in, 26-bit RGBStr word and
// frame/line pulses out.
interface pxs_stream_gen_if;
  logic        en;
  logic [25:0] RGBStr_o;
  logic        frame_o;
  logic        line_o;

  modport master (input en, output RGBStr_o, output frame_o, output line_o);
  modport slave  (output en, input RGBStr_o, input frame_o, input line_o);
endinterface

// File: rtl/pxs_stream_gen.sv
// Head of the pixel pipeline: free-running h/v raster counters turned into a
// registered RGBStr word (syncs, active flag, raw coordinates, blank RGB).
module pxs_stream_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic              px_clk,
  input  logic              rst_n,
  pxs_stream_gen_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
    $error("pxs_stream_gen: H_TOTAL/V_TOTAL exceed the 10-bit coordinate fields");
  end

  // Thresholds are one bit wider than the counters so H_ACTIVE = 1024 still compares correctly.
  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [25:0] WORD_RESET = {~SYNC_POL, ~SYNC_POL, 24'b0};

  function automatic logic sync_level(input logic asserted);
    return asserted ? SYNC_POL : ~SYNC_POL;
  endfunction

  logic [9:0]  h_p0;
  logic [9:0]  v_p0;
  logic        active;
  logic        hsync;
  logic        vsync;
  logic [25:0] word_p1;
  logic        frame_p1;
  logic        line_p1;

  always_comb begin
    active = ({1'b0, h_p0} < H_ACT_END) && ({1'b0, v_p0} < V_ACT_END);
    hsync  = sync_level(({1'b0, h_p0} >= HS_START) && ({1'b0, h_p0} < HS_END));
    vsync  = sync_level(({1'b0, v_p0} >= VS_START) && ({1'b0, v_p0} < VS_END));
  end

  // Stage p0 -> p1: word is built from the current counters, counters advance.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_p0     <= '0;
      v_p0     <= '0;
      word_p1  <= WORD_RESET;
      frame_p1 <= 1'b0;
      line_p1  <= 1'b0;
    end else if (bus.en) begin
      word_p1  <= {hsync, vsync, active, h_p0, v_p0, 3'b000};
      line_p1  <= (h_p0 == 10'd0);
      frame_p1 <= (h_p0 == 10'd0) && (v_p0 == 10'd0);
      if (h_p0 == H_LAST) begin
        h_p0 <= '0;
        v_p0 <= (v_p0 == V_LAST) ? 10'd0 : v_p0 + 10'd1;
      end else begin
        h_p0 <= h_p0 + 10'd1;
      end
    end
  end

  assign bus.RGBStr_o = word_p1;
  assign bus.frame_o  = frame_p1;
  assign bus.line_o   = line_p1;

endmodule
